// File: rtl/lock_guard.sv
// Code lock controller: checks submitted codes, holds the lock open for OPEN_SEC
// seconds and locks out after MAX_FAIL misses. Define LOCK_GUARD_ALARM_EN for the buzzer.
module lock_guard #(
    parameter int CLK_FREQ = 50000000,
    parameter int MAX_FAIL = 3,
    parameter int OPEN_SEC = 5,
    parameter int LOCK_SEC = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enter_trig,
    input  logic       init_trig,
    input  logic       com_result,
    output logic       unlock,
    output logic       locked_out,
    output logic [3:0] fail_cnt,
    output logic [3:0] sec_left,
    output logic       alarm
);

    localparam int PRESC_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ - 1);
    localparam logic [3:0] MAX4  = 4'(MAX_FAIL);
    localparam logic [3:0] OPEN4 = 4'(OPEN_SEC);
    localparam logic [3:0] LOCK4 = 4'(LOCK_SEC);

    typedef enum logic [1:0] {IDLE, CHECK, OPEN, LOCKOUT} state_t;

    state_t             state, next_state;
    logic [3:0]         fail_next, sec_next, fail_inc;
    logic [PRESC_W-1:0] presc;
    logic               timed, tick, entering;

    assign timed    = (state == OPEN) || (state == LOCKOUT);
    assign tick     = timed && (presc == PRESC_MAX);
    assign entering = (next_state != state);
    assign fail_inc = (fail_cnt >= MAX4) ? MAX4 : fail_cnt + 4'd1;

    always_comb begin
        next_state = state;
        fail_next  = fail_cnt;
        sec_next   = sec_left;
        case (state)
            IDLE: begin
                sec_next = 4'd0;
                if (init_trig)
                    fail_next = 4'd0;
                if (enter_trig)
                    next_state = CHECK;
            end
            CHECK: begin
                if (com_result) begin
                    fail_next  = 4'd0;
                    sec_next   = OPEN4;
                    next_state = OPEN;
                end else begin
                    fail_next = fail_inc;
                    if (fail_inc == MAX4) begin
                        sec_next   = LOCK4;
                        next_state = LOCKOUT;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            OPEN: begin
                if (init_trig)
                    fail_next = 4'd0;
                // A submit while open relocks without consulting the comparator
                if (enter_trig) begin
                    sec_next   = 4'd0;
                    next_state = IDLE;
                end else if (tick) begin
                    if (sec_left <= 4'd1) begin
                        sec_next   = 4'd0;
                        next_state = IDLE;
                    end else begin
                        sec_next = sec_left - 4'd1;
                    end
                end
            end
            LOCKOUT: begin
                if (tick) begin
                    if (sec_left <= 4'd1) begin
                        sec_next   = 4'd0;
                        fail_next  = 4'd0;
                        next_state = IDLE;
                    end else begin
                        sec_next = sec_left - 4'd1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fail_cnt   <= 4'd0;
            sec_left   <= 4'd0;
            presc      <= '0;
            unlock     <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= next_state;
            fail_cnt   <= fail_next;
            sec_left   <= sec_next;
            unlock     <= (next_state == OPEN);
            locked_out <= (next_state == LOCKOUT);
            // Prescaler restarts whenever a timed state is (re)entered
            if (entering || !((next_state == OPEN) || (next_state == LOCKOUT)) || tick)
                presc <= '0;
            else
                presc <= presc + 1'b1;
        end
    end

`ifdef LOCK_GUARD_ALARM_EN
    localparam int ALARM_DIV = (CLK_FREQ / 4 < 1) ? 1 : CLK_FREQ / 4;
    localparam int ALARM_W   = (ALARM_DIV > 1) ? $clog2(ALARM_DIV) : 1;
    localparam logic [ALARM_W-1:0] ALARM_MAX = ALARM_W'(ALARM_DIV - 1);

    logic [ALARM_W-1:0] alarm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm     <= 1'b0;
            alarm_cnt <= '0;
        end else if (next_state == LOCKOUT) begin
            if (state != LOCKOUT) begin
                alarm     <= 1'b1;
                alarm_cnt <= '0;
            end else if (alarm_cnt == ALARM_MAX) begin
                alarm     <= ~alarm;
                alarm_cnt <= '0;
            end else begin
                alarm_cnt <= alarm_cnt + 1'b1;
            end
        end else begin
            alarm     <= 1'b0;
            alarm_cnt <= '0;
        end
    end
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_lock_guard.sv
// Directed bench for lock_guard at CLK_FREQ=8, MAX_FAIL=3, OPEN_SEC=2, LOCK_SEC=3.
// Alarm expectations follow LOCK_GUARD_ALARM_EN.
module tb_lock_guard;

    logic       clk = 1'b0;
    logic       rst;
    logic       enter_trig, init_trig, com_result;
    logic       unlock, locked_out, alarm;
    logic [3:0] fail_cnt, sec_left;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    lock_guard #(.CLK_FREQ(8), .MAX_FAIL(3), .OPEN_SEC(2), .LOCK_SEC(3)) dut (
        .clk(clk), .rst(rst), .enter_trig(enter_trig), .init_trig(init_trig),
        .com_result(com_result), .unlock(unlock), .locked_out(locked_out),
        .fail_cnt(fail_cnt), .sec_left(sec_left), .alarm(alarm)
    );

    typedef struct {
        logic       enter, init, com;
        logic       exp_unlock, exp_locked;
        logic [3:0] exp_fail, exp_sec;
    } vec_t;

    vec_t vecs[17];

    // Inputs hold for one cycle; outputs are sampled just after the edge
    task automatic apply_stimulus(input logic e, input logic i, input logic c);
        @(negedge clk);
        enter_trig = e;
        init_trig  = i;
        com_result = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic u, input logic l,
                                input logic [3:0] f, input logic [3:0] s, input logic a);
        checks++;
        if ({unlock, locked_out, fail_cnt, sec_left, alarm} === {u, l, f, s, a})
            passes++;
        else
            $display("[TB] FAIL %s: got unlock=%0b locked_out=%0b fail_cnt=%0d sec_left=%0d alarm=%0b, required unlock=%0b locked_out=%0b fail_cnt=%0d sec_left=%0d alarm=%0b",
                     name, unlock, locked_out, fail_cnt, sec_left, alarm, u, l, f, s, a);
    endtask

    function automatic logic lock_alarm(input int j);
`ifdef LOCK_GUARD_ALARM_EN
        return ((j / 2) % 2) == 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic fail_three();
        apply_stimulus(1, 0, 0);
        apply_stimulus(0, 0, 0);
        check_output("fail1", 0, 0, 4'd1, 4'd0, 0);
        apply_stimulus(1, 0, 0);
        apply_stimulus(0, 0, 0);
        check_output("fail2", 0, 0, 4'd2, 4'd0, 0);
        apply_stimulus(1, 0, 0);
        apply_stimulus(0, 0, 0);
        check_output("fail3_lock", 0, 1, 4'd3, 4'd3, lock_alarm(0));
    endtask

    initial begin
        //                enter init com  unl lck fail  sec
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd2};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};

        rst = 1'b1;
        enter_trig = 1'b0;
        init_trig  = 1'b0;
        com_result = 1'b0;
        apply_stimulus(0, 0, 0);
        apply_stimulus(1, 1, 1);
        check_output("reset_state", 0, 0, 4'd0, 4'd0, 0);
        rst = 1'b0;

        for (int v = 0; v < 17; v++) begin
            apply_stimulus(vecs[v].enter, vecs[v].init, vecs[v].com);
            check_output($sformatf("vec%0d", v), vecs[v].exp_unlock, vecs[v].exp_locked,
                         vecs[v].exp_fail, vecs[v].exp_sec, 1'b0);
        end

        // Full open window: 16 cycles of unlock, seconds 2 then 1
        apply_stimulus(1, 0, 0);
        apply_stimulus(0, 0, 1);
        check_output("open_k0", 1, 0, 4'd0, 4'd2, 0);
        for (int k = 1; k < 16; k++) begin
            apply_stimulus(0, 0, 0);
            check_output($sformatf("open_k%0d", k), 1, 0, 4'd0, (k < 8) ? 4'd2 : 4'd1, 0);
        end
        apply_stimulus(0, 0, 0);
        check_output("open_expire", 0, 0, 4'd0, 4'd0, 0);

        // Full lockout: 24 cycles, triggers at j=5 must be ignored
        fail_three();
        for (int j = 1; j < 24; j++) begin
            apply_stimulus(j == 5, j == 5, 0);
            check_output($sformatf("lock_j%0d", j), 0, 1, 4'd3, 4'(3 - j / 8), lock_alarm(j));
        end
        apply_stimulus(0, 0, 0);
        check_output("lock_expire", 0, 0, 4'd0, 4'd0, 0);

        // Reset in the middle of lockout
        fail_three();
        for (int j = 1; j < 4; j++)
            apply_stimulus(0, 0, 0);
        check_output("lock_before_rst", 0, 1, 4'd3, 4'd3, lock_alarm(3));
        rst = 1'b1;
        apply_stimulus(1, 1, 1);
        check_output("rst_mid_lock", 0, 0, 4'd0, 4'd0, 0);
        rst = 1'b0;

        // Reset in the middle of open
        apply_stimulus(1, 0, 0);
        apply_stimulus(0, 0, 1);
        apply_stimulus(0, 0, 0);
        check_output("open_before_rst", 1, 0, 4'd0, 4'd2, 0);
        rst = 1'b1;
        apply_stimulus(0, 0, 0);
        check_output("rst_mid_open", 0, 0, 4'd0, 4'd0, 0);
        rst = 1'b0;
        apply_stimulus(0, 0, 0);
        check_output("idle_after_rst", 0, 0, 4'd0, 4'd0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lock_guard.md
LOCK_GUARD -- requirements
Module: lock_guard

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, clock cycles per second tick.
REQ-002 SHALL have parameter MAX_FAIL, default 3, consecutive failures that trigger lockout (range 1..15).
REQ-003 SHALL have parameter OPEN_SEC, default 5, unlock hold time in seconds (range 1..15).
REQ-004 SHALL have parameter LOCK_SEC, default 10, lockout time in seconds (range 1..15).
REQ-005 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port enter_trig, input, 1, single-cycle code-submit pulse from key handling.
REQ-008 SHALL have port init_trig, input, 1, single-cycle pulse that clears the failure count.
REQ-009 SHALL have port com_result, input, 1, compare result; valid the cycle after enter_trig; 1 means match.
REQ-010 SHALL have port unlock, output, 1, lock-open drive.
REQ-011 SHALL have port locked_out, output, 1, high during lockout.
REQ-012 SHALL have port fail_cnt, output, 4, current consecutive failure count.
REQ-013 SHALL have port sec_left, output, 4, whole seconds remaining in OPEN or LOCKOUT, else 0.
REQ-014 SHALL have port alarm, output, 1, buzzer drive.

Function
REQ-015 SHALL implement FSM states IDLE, CHECK, OPEN, LOCKOUT.
REQ-016 In IDLE, enter_trig SHALL move to CHECK on the next edge.
REQ-017 CHECK SHALL last exactly one cycle and sample com_result in that cycle.
REQ-018 com_result=1 in CHECK SHALL clear fail_cnt, enter OPEN, and load sec_left=OPEN_SEC.
REQ-019 com_result=0 in CHECK SHALL increment fail_cnt by 1.
REQ-020 If the incremented fail_cnt equals MAX_FAIL, SHALL enter LOCKOUT and load sec_left=LOCK_SEC; otherwise SHALL return to IDLE.
REQ-021 unlock SHALL be 1 exactly while in OPEN; locked_out SHALL be 1 exactly while in LOCKOUT; both registered.
REQ-022 The prescaler SHALL count 0..CLK_FREQ-1, restart at 0 on entry to OPEN or LOCKOUT, and emit one tick per wrap.
REQ-023 Each tick SHALL decrement sec_left; the tick that takes sec_left 1->0 SHALL return to IDLE in the same edge.
REQ-024 OPEN SHALL therefore last exactly OPEN_SEC*CLK_FREQ cycles unless relocked.
REQ-025 enter_trig in OPEN SHALL relock immediately: go to IDLE, sec_left=0, with no compare.
REQ-026 Leaving LOCKOUT SHALL clear fail_cnt to 0.
REQ-027 enter_trig and init_trig SHALL be ignored in CHECK and LOCKOUT.
REQ-028 init_trig in IDLE or OPEN SHALL clear fail_cnt without changing state.
REQ-029 When enter_trig and init_trig coincide in IDLE, SHALL clear fail_cnt and go to CHECK.
REQ-030 fail_cnt SHALL saturate at MAX_FAIL and never wrap.

Reset
REQ-031 rst SHALL force IDLE, fail_cnt=0, sec_left=0, prescaler=0, unlock=0, locked_out=0, alarm=0 on the next edge.
REQ-032 rst SHALL take priority over all other inputs, including mid-OPEN and mid-LOCKOUT.

Configuration
REQ-033 Macro LOCK_GUARD_ALARM_EN SHALL gate the alarm feature.
REQ-034 With LOCK_GUARD_ALARM_EN defined, alarm SHALL toggle every CLK_FREQ/4 cycles (2 Hz square wave) during LOCKOUT, start at 1 on LOCKOUT entry, and be 0 outside LOCKOUT.
REQ-035 Without LOCK_GUARD_ALARM_EN, alarm SHALL be constant 0 and no alarm counter SHALL be built.

Verification
REQ-036 With CLK_FREQ=8, OPEN_SEC=2: pulse enter_trig with com_result=1 next cycle -> unlock=1 two cycles later, sec_left 2->1->0, unlock=0 after 16 cycles.
REQ-037 With MAX_FAIL=3, LOCK_SEC=3: three mismatching submits -> fail_cnt 1,2,3; locked_out=1; enter_trig ignored; after 24 cycles locked_out=0 and fail_cnt=0.
REQ-038 Two failures, then init_trig in IDLE -> fail_cnt=0; next failure gives fail_cnt=1 with no lockout.
REQ-039 In OPEN, enter_trig -> unlock=0 next edge, state IDLE, fail_cnt unchanged at 0.
REQ-040 rst asserted mid-LOCKOUT -> next edge all outputs 0; with LOCK_GUARD_ALARM_EN and CLK_FREQ=8, alarm toggles every 2 cycles during LOCKOUT, and is 0 throughout when the macro is undefined.
